store_write_buffer: RTL

//  Post-retirement FIFO between the store queue head and the memory bus. At store retire it captures the SQ head {addr,data}, so the SQ entry frees that same cycle.

---
 rtl/store_write_buffer_pkg.sv | 27 ++
 rtl/store_write_buffer_fwd_match.sv | 35 +++
 rtl/store_write_buffer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared definitions for the post-retirement store write buffer:
// buffer geometry, index/state types and memory bus command encoding.
package store_write_buffer_pkg;

  localparam int WB_SIZE  = 4;
  localparam int WB_IDX_W = $clog2(WB_SIZE);

  typedef logic [WB_IDX_W-1:0] WB_IDX_T;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_SEND = 2'd1,
    WB_DONE = 2'd2
  } WB_STATE_T;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND_T;

  // Circular index increment; WB_SIZE is a power of 2 so wrap is free.
  function automatic WB_IDX_T wb_idx_inc(input WB_IDX_T idx);
    return idx + WB_IDX_T'(1);
  endfunction

endpackage

// File: rtl/store_write_buffer_fwd_match.sv
// wb_fwd_match: picks the youngest requesting entry of the circular buffer.
// Requests are rotated so position 0 is the head (oldest); the highest set
// position is the youngest, which is then mapped back to a buffer index.
module wb_fwd_match
  import store_write_buffer_pkg::*;
(
  input  logic [WB_SIZE-1:0] i_req,
  input  WB_IDX_T            i_head,
  output logic               o_hit,
  output WB_IDX_T            o_idx
);

  logic [WB_SIZE-1:0] w_rot;
  WB_IDX_T            w_pos;

  // Rotate requests into age order: w_rot[k] is the entry k places after head.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < WB_SIZE; k++) begin
      w_rot[k] = i_req[i_head + WB_IDX_T'(k)];
    end
  end

  // Select the highest (youngest) set position and encode it.
  always_comb begin
    w_pos = '0;
    for (int k = 0; k < WB_SIZE; k++) begin
      if (w_rot[k]) w_pos = WB_IDX_T'(k);
    end
  end

  assign o_hit = |w_rot;
  assign o_idx = i_head + w_pos;

endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: FIFO between the store queue head and the memory bus.
// Captures retiring stores, drains them oldest-first as BUS_STORE commands,
// and forwards data of retired-but-unwritten stores to loads.
// Optional feature: define WB_COALESCE_EN to merge a retiring store into a
// younger, non-head entry with the same address instead of allocating.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  WB_IDLE | buffer empty, no flush pending
//  WB_SEND | entries held; head is issued whenever the arbiter grants
//  WB_DONE | drained while flush is high; flush_done asserted
module store_write_buffer
  import store_write_buffer_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_rt_en,
  input  logic [31:0] i_rt_addr,
  input  logic [63:0] i_rt_data,
  input  logic        i_ld_rd_en,
  input  logic [31:0] i_ld_addr,
  input  logic        i_flush,
  input  logic        i_mem_gnt,
  input  logic [3:0]  i_mem2proc_response,
  output logic [1:0]  o_proc2mem_command,
  output logic [63:0] o_proc2mem_addr,
  output logic [63:0] o_proc2mem_data,
  output logic        o_wb_req,
  output logic [63:0] o_ld_data,
  output logic        o_ld_hit,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_flush_done
);

  localparam logic [WB_IDX_W:0] LP_FULL_COUNT = (WB_IDX_W+1)'(WB_SIZE);

  logic [31:0]        r_addr [WB_SIZE];
  logic [63:0]        r_data [WB_SIZE];
  logic [WB_SIZE-1:0] r_valid;
  WB_IDX_T            r_head;
  WB_IDX_T            r_tail;
  logic [WB_IDX_W:0]  r_count;
  WB_STATE_T          r_state;

  logic               w_full;
  logic               w_empty;
  logic               w_send;
  logic               w_accept;
  logic               w_coal;
  logic               w_enq;
  logic [WB_IDX_W:0]  w_count_next;
  logic [WB_SIZE-1:0] w_fwd_req;
  logic               w_fwd_hit;
  WB_IDX_T            w_fwd_idx;
  logic               w_byp_hit;

  assign w_full   = (r_count == LP_FULL_COUNT);
  assign w_empty  = (r_count == '0);
  assign w_send   = (r_state == WB_SEND) && i_mem_gnt;
  assign w_accept = w_send && (i_mem2proc_response != 4'd0);

`ifdef WB_COALESCE_EN
  logic [WB_SIZE-1:0] w_coal_req;
  logic               w_coal_hit;
  WB_IDX_T            w_coal_idx;

  // Head is excluded: it may already be on the bus, so it must not change.
  always_comb begin
    w_coal_req = '0;
    for (int i = 0; i < WB_SIZE; i++) begin
      w_coal_req[i] = r_valid[i] && (r_addr[i] == i_rt_addr) && (WB_IDX_T'(i) != r_head);
    end
  end

  wb_fwd_match u_coal_match (
    .i_req  (w_coal_req),
    .i_head (r_head),
    .o_hit  (w_coal_hit),
    .o_idx  (w_coal_idx)
  );

  assign w_coal = i_rt_en && w_coal_hit;
`else
  assign w_coal = 1'b0;
`endif

  // A full buffer still accepts a retire when the head drains the same cycle.
  assign w_enq        = i_rt_en && !w_coal && (!w_full || w_accept);
  assign w_count_next = r_count + (WB_IDX_W+1)'(w_enq) - (WB_IDX_W+1)'(w_accept);

  // Entry storage, head/tail pointers and occupancy count.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int i = 0; i < WB_SIZE; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= wb_idx_inc(r_head);
      end
      // Placed after the dequeue so a same-slot free-then-fill keeps valid set.
      if (w_enq) begin
        r_addr[r_tail]  <= i_rt_addr;
        r_data[r_tail]  <= i_rt_data;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= wb_idx_inc(r_tail);
      end
`ifdef WB_COALESCE_EN
      if (w_coal) begin
        r_data[w_coal_idx] <= i_rt_data;
      end
`endif
      r_count <= w_count_next;
    end
  end

  // Drain/flush state machine; looks at next occupancy so a retire is
  // issued on the very next cycle.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= WB_IDLE;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (w_count_next != '0) r_state <= WB_SEND;
          else if (i_flush)       r_state <= WB_DONE;
        end
        WB_SEND: begin
          if (w_accept && (w_count_next == '0)) r_state <= i_flush ? WB_DONE : WB_IDLE;
        end
        WB_DONE: begin
          if (w_count_next != '0) r_state <= WB_SEND;
          else if (!i_flush)      r_state <= WB_IDLE;
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  // Load forwarding: buffered entries, plus the store entering this cycle.
  always_comb begin
    w_fwd_req = '0;
    for (int i = 0; i < WB_SIZE; i++) begin
      w_fwd_req[i] = r_valid[i] && (r_addr[i] == i_ld_addr);
    end
  end

  wb_fwd_match u_fwd_match (
    .i_req  (w_fwd_req),
    .i_head (r_head),
    .o_hit  (w_fwd_hit),
    .o_idx  (w_fwd_idx)
  );

  assign w_byp_hit = (w_enq || w_coal) && (i_rt_addr == i_ld_addr);

  // The bypassed store is youngest, so it wins over any buffered match.
  always_comb begin
    o_ld_hit  = 1'b0;
    o_ld_data = '0;
    if (i_ld_rd_en) begin
      if (w_byp_hit) begin
        o_ld_hit  = 1'b1;
        o_ld_data = i_rt_data;
      end else if (w_fwd_hit) begin
        o_ld_hit  = 1'b1;
        o_ld_data = r_data[w_fwd_idx];
      end
    end
  end

  assign o_proc2mem_command = w_send ? BUS_STORE : BUS_NONE;
  assign o_proc2mem_addr    = {32'b0, r_addr[r_head]};
  assign o_proc2mem_data    = r_data[r_head];
  assign o_wb_req           = !w_empty;
  assign o_full             = w_full;
  assign o_empty            = w_empty;
  assign o_flush_done       = (r_state == WB_DONE);

  a_no_retire_when_full : assert property (
    @(posedge i_clock) disable iff (!i_reset)
    !(i_rt_en && w_full && !w_accept && !w_coal)
  );

endmodule
